params_burst_reader: RTL and testbench

- Read-side initiator for the parameters memory: fetches a contiguous burst of parameter words and presents them as a valid/ready stream to compute units.
- Drives the memory read port (en/addr/format), absorbs the memory's single-cycle read latency, and applies backpressure with a 2-entry output FIFO.
- Bank 0/1 split is handled by the memory; this block sees a flat address space.

---
 rtl/params_burst_reader_if.sv | 36 +++
 rtl/params_burst_reader.sv | 148 ++++++++++++++
 tb/tb_params_burst_reader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/params_burst_reader_if.sv
// Request, memory read-port and output-stream signals of the parameter burst reader.
// master = the reader itself, slave = the requester/memory/consumer side.
interface params_burst_reader_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 22,
  parameter int unsigned FMT_W  = 2,
  parameter int unsigned LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic [FMT_W-1:0]  format;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [FMT_W-1:0]  mem_rd_format;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  start, start_addr, length, format, mem_rd_data, out_ready,
    output busy, done, err, mem_rd_en, mem_rd_addr, mem_rd_format, out_valid, out_data,
           out_last
  );

  modport slave (
    output start, start_addr, length, format, mem_rd_data, out_ready,
    input  busy, done, err, mem_rd_en, mem_rd_addr, mem_rd_format, out_valid, out_data,
           out_last
  );
endinterface

// File: rtl/params_burst_reader.sv
// Burst read initiator for the parameters memory: issues sequential reads, absorbs the
// one-cycle read latency and streams words out through a 2-entry fall-through FIFO.
module params_burst_reader #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 22,
  parameter int unsigned FMT_W       = 2,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned TOTAL_WORDS = 31744
) (
  input logic                   clk,
  input logic                   rst,
  params_burst_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  localparam int unsigned SumW   = LEN_W + 1;
  localparam int unsigned EntryW = DATA_W + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [FMT_W-1:0]  fmt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [EntryW-1:0] fifo_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;

  logic [SumW-1:0]   end_addr;
  logic              range_bad;
  logic [EntryW-1:0] head;
  logic              fifo_valid;
  logic              head_last;
  logic              pop;
  logic              push;
  logic              issue;
  logic              fmt_active;

  always_comb begin
    end_addr   = SumW'(bus.start_addr) + SumW'(bus.length);
    range_bad  = end_addr > SumW'(TOTAL_WORDS);
    head       = fifo_q[rd_ptr_q];
    fifo_valid = count_q != 2'd0;
    head_last  = head[DATA_W];
    pop        = fifo_valid && bus.out_ready;
    push       = inflight_q;
    // Buffered plus in-flight words never exceed the two FIFO slots.
    issue      = (state_q == StIssue) &&
                 (((3'(count_q) + 3'(inflight_q)) < 3'd2) || pop);
    // Memory casts data on return, so the format must outlive the final read by a cycle.
    fmt_active = (state_q == StIssue) || ((state_q == StDrain) && inflight_q);
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.mem_rd_en     = issue;
  assign bus.mem_rd_addr   = issue ? addr_q : '0;
  assign bus.mem_rd_format = fmt_active ? fmt_q : '0;
  assign bus.out_valid     = fifo_valid;
  assign bus.out_data      = fifo_valid ? head[DATA_W-1:0] : '0;
  assign bus.out_last      = fifo_valid && head_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      fmt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.length == '0) begin
              done_q <= 1'b1;
            end else if (range_bad) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= bus.start_addr;
              rem_q   <= bus.length;
              fmt_q   <= bus.format;
              busy_q  <= 1'b1;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && head_last) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_last_q <= rem_q == LEN_W'(1);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_last_q, bus.mem_rd_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

`ifdef ENABLE_ASSERTIONS
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == 2'd2)));
`endif

endmodule

// File: tb/tb_params_burst_reader.sv
// Directed bench for params_burst_reader with a queue-based reference model that checks
// reads, stream words and status pulses every cycle.
module tb_params_burst_reader;

  localparam int unsigned ADDR_W      = 15;
  localparam int unsigned DATA_W      = 22;
  localparam int unsigned FMT_W       = 2;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned TOTAL_WORDS = 31744;
  localparam logic [FMT_W-1:0] FMT_FX_4_X = 2'd1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   t0 = 0;
  int   checks = 0;
  int   errors = 0;

  params_burst_reader_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FMT_W(FMT_W), .LEN_W(LEN_W)
  ) bus ();

  params_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FMT_W(FMT_W), .LEN_W(LEN_W),
    .TOTAL_WORDS(TOTAL_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[6:0] ^ 7'h2B, a};
  endfunction

  // Memory with single-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_rd_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [ADDR_W-1:0] rd_q[$];
  logic [DATA_W:0]   st_q[$];
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic              m_err = 1'b0;
  logic [FMT_W-1:0]  m_fmt = '0;
  int                outstanding = 0;

  always @(negedge clk) begin
    logic nb, nd, ne;
    logic [DATA_W:0] w;
    logic [ADDR_W-1:0] a;
    if (rst) begin
      rd_q.delete();
      st_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      outstanding = 0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_out_valid", bus.out_valid, 0);
    end else begin
      chk("done", bus.done, m_done);
      chk("err", bus.err, m_err);
      chk("busy", bus.busy, m_busy);
      nb = m_busy;
      nd = 1'b0;
      ne = 1'b0;
      if (!m_busy) chk("fmt_idle", bus.mem_rd_format, 0);
      if (bus.mem_rd_en) begin
        chk("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) chk("rd_addr", bus.mem_rd_addr, rd_q.pop_front());
        chk("rd_fmt", bus.mem_rd_format, m_fmt);
        outstanding++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("st_expected", st_q.size() != 0, 1);
        if (st_q.size() != 0) begin
          w = st_q.pop_front();
          chk("out_data", bus.out_data, w[DATA_W-1:0]);
          chk("out_last", bus.out_last, w[DATA_W]);
          if (w[DATA_W]) begin
            nd = 1'b1;
            nb = 1'b0;
          end
        end
        outstanding--;
      end
      if (bus.mem_rd_en) chk("outstanding_le_2", outstanding <= 2, 1);
      if (bus.start && !m_busy) begin
        if (bus.length == '0) begin
          nd = 1'b1;
        end else if (int'(bus.start_addr) + int'(bus.length) > TOTAL_WORDS) begin
          ne = 1'b1;
        end else begin
          nb = 1'b1;
          m_fmt = bus.format;
          for (int i = 0; i < int'(bus.length); i++) begin
            a = bus.start_addr + ADDR_W'(i);
            rd_q.push_back(a);
            st_q.push_back({i == int'(bus.length) - 1, mem_word(a)});
          end
        end
      end
      m_busy = nb;
      m_done = nd;
      m_err = ne;
    end
  end

  task automatic go(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                    input logic [FMT_W-1:0] f);
    bus.start = 1'b1;
    bus.start_addr = a;
    bus.length = l;
    bus.format = f;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_until_done(input int max, input int exp_rel, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        chk(name, cyc - t0, exp_rel);
      end
      @(posedge clk); #1;
    end
    chk({name, "_seen"}, seen, 1);
  endtask

  int rd_bp, nrd, nw, nlast, last_idx, ndone;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.length = '0;
    bus.format = '0;
    bus.out_ready = 1'b1;
    #7;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_rd_addr", bus.mem_rd_addr, 0);
    chk("reset_rd_fmt", bus.mem_rd_format, 0);
    chk("reset_out_data", bus.out_data, 0);
    chk("reset_out_last", bus.out_last, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single word.
    go(15'd5, 16'd1, FMT_FX_4_X);
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      chk("t1_rd_en", bus.mem_rd_en, r == 1);
      if (r == 1) begin
        chk("t1_rd_addr", bus.mem_rd_addr, 5);
        chk("t1_rd_fmt", bus.mem_rd_format, FMT_FX_4_X);
      end
      chk("t1_out_valid", bus.out_valid, r == 3);
      if (r == 3) begin
        chk("t1_out_data", bus.out_data, 22'h170005);
        chk("t1_out_last", bus.out_last, 1);
      end
      chk("t1_done", bus.done, r == 4);
      @(posedge clk); #1;
    end

    // Bank crossing.
    go(15'd15870, 16'd4, 2'd2);
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      chk("t2_rd_en", bus.mem_rd_en, r >= 1 && r <= 4);
      if (r <= 4) chk("t2_rd_addr", bus.mem_rd_addr, 15870 + r - 1);
      chk("t2_out_valid", bus.out_valid, r >= 3 && r <= 6);
      chk("t2_done", bus.done, r == 7);
      @(posedge clk); #1;
    end

    // Backpressure.
    go(15'd0, 16'd8, 2'd2);
    rd_bp = 0; nrd = 0; nw = 0; nlast = 0; last_idx = 0; ndone = 0;
    for (int r = 1; r <= 25; r++) begin
      bus.out_ready = !(r >= 4 && r <= 9);
      @(negedge clk);
      if (bus.mem_rd_en) begin
        nrd++;
        if (r >= 4 && r <= 9) rd_bp++;
      end
      if (bus.out_valid && bus.out_ready) begin
        nw++;
        if (bus.out_last) begin
          nlast++;
          last_idx = nw;
        end
      end
      if (bus.done) ndone++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    chk("t3_reads_while_stalled", rd_bp, 0);
    chk("t3_reads", nrd, 8);
    chk("t3_words", nw, 8);
    chk("t3_last_count", nlast, 1);
    chk("t3_last_index", last_idx, 8);
    chk("t3_done_count", ndone, 1);

    // Rejections.
    go(15'd10, 16'd0, 2'd0);
    @(negedge clk);
    chk("t4_len0_done", bus.done, 1);
    chk("t4_len0_no_rd", bus.mem_rd_en, 0);
    chk("t4_len0_busy", bus.busy, 0);
    @(posedge clk); #1;
    go(15'd31740, 16'd5, 2'd0);
    @(negedge clk);
    chk("t4_range_err", bus.err, 1);
    chk("t4_range_no_rd", bus.mem_rd_en, 0);
    chk("t4_range_busy", bus.busy, 0);
    @(posedge clk); #1;
    go(15'd31740, 16'd4, FMT_FX_4_X);
    run_until_done(20, 7, "t4_edge_done");

    // Start while busy is ignored.
    go(15'd200, 16'd6, 2'd3);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.start_addr = 15'd500;
    bus.length = 16'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    run_until_done(20, 9, "t5_done");
    chk("t5_rd_q_empty", rd_q.size(), 0);

    // Reset mid-burst during word 3.
    go(15'd0, 16'd8, FMT_FX_4_X);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_valid", bus.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_err", bus.err, 0);
    chk("t6_rd_en", bus.mem_rd_en, 0);
    chk("t6_rd_addr", bus.mem_rd_addr, 0);
    chk("t6_rd_fmt", bus.mem_rd_format, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_out_data", bus.out_data, 0);
    chk("t6_out_last", bus.out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    go(15'd100, 16'd2, 2'd2);
    run_until_done(20, 5, "t6_restart_done");

    repeat (3) @(posedge clk);
    #1;
    chk("end_rd_q_empty", rd_q.size(), 0);
    chk("end_st_q_empty", st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
